// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// sar_pkg
// ----------------------------------------------------------------------------
// Shared types and helpers for the successive-approximation ADC controller.
//   sar_state_t         : controller FSM states (IDLE, SETTLE, DECIDE)
//   SAR_WIDTH           : default result / DAC code width
//   settle_cnt_width()  : width of the per-trial settle counter
// Revision: 1.0 - initial release
// ============================================================================
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2
  } sar_state_t;

  localparam int SAR_WIDTH = 8;

  // The settle counter must reach SETTLE_CYCLES+SYNC_STAGES-1.
  function automatic int settle_cnt_width(input int settle_cycles, input int sync_stages);
    int w;
    w = $clog2(settle_cycles + sync_stages);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : sar_pkg
`default_nettype wire

// File: rtl/sar_sync.sv
`default_nettype none
// ============================================================================
// sar_sync
// ----------------------------------------------------------------------------
// Multi-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset, clears every stage to 0
//   async_in  : asynchronous input
//   sync_out  : synchronized output (last stage of the chain)
// Revision: 1.0 - initial release
// ============================================================================
module sar_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule : sar_sync
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// sar_adc_ctrl
// ----------------------------------------------------------------------------
// Successive-approximation controller driving an external R-2R ladder and
// reading back an open-loop OTA used as comparator.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   start     : conversion request, sampled only in IDLE
//   abort     : synchronous cancel, overrides everything but rst
//   cmp_in    : asynchronous comparator output, 1 = DAC above input
//   dac_code  : current trial code to the ladder
//   busy      : conversion in progress
//   done      : one-cycle pulse when result updates
//   result    : last completed conversion
// Revision: 1.0 - initial release
// ============================================================================
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = settle_cnt_width(SETTLE_CYCLES, SYNC_STAGES);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CODE_MSB = WIDTH'(1) << (WIDTH - 1);

  sar_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             cmp_s;
  logic [IDX_W-1:0] idx_dn;
  logic [WIDTH-1:0] trial_next;

  sar_sync #(
    .STAGES (SYNC_STAGES)
  ) u_cmp_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (cmp_in),
    .sync_out (cmp_s)
  );

  assign idx_dn = idx - IDX_W'(1);

  // Code after the current bit decision: drop the bit under test if the DAC
  // overshot the input, then raise the next lower bit as the new trial.
  always_comb begin
    trial_next = dac_code;
    if (cmp_s) begin
      trial_next[idx] = 1'b0;
    end
    if (idx != '0) begin
      trial_next[idx_dn] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= IDX_MSB;
      cnt      <= '0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        dac_code <= '0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (start) begin
              state    <= SETTLE;
              dac_code <= CODE_MSB;
              idx      <= IDX_MSB;
              cnt      <= '0;
              busy     <= 1'b1;
            end
          end
          SETTLE: begin
            // Settle window also covers the synchronizer latency.
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= DECIDE;
            end
          end
          DECIDE: begin
            dac_code <= trial_next;
            if (idx != '0) begin
              idx   <= idx_dn;
              cnt   <= '0;
              state <= SETTLE;
            end else begin
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= trial_next;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : sar_adc_ctrl
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sar_adc_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for sar_adc_ctrl with an ideal comparator model
// (cmp_in = dac_code > vin) and a result/latency scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

  localparam int WIDTH         = 8;
  localparam int SETTLE_CYCLES = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int LATENCY       = WIDTH * (SETTLE_CYCLES + SYNC_STAGES + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] vin;

  typedef struct {
    logic [WIDTH-1:0] val;
    int               se;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] trial[$];
  int               checks   = 0;
  int               errors   = 0;
  int               edge_cnt = 0;
  int               done_cnt = 0;
  logic             prev_busy = 1'b0;
  logic [WIDTH-1:0] last_code = '0;

  sar_adc_ctrl #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cmp_in   (cmp_in),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  assign cmp_in = (dac_code > vin);

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called on the negedge where start is driven; the next edge samples it.
  task automatic push_exp(input logic [WIDTH-1:0] v);
    exp_t e;
    e.val = v;
    e.se  = edge_cnt + 1;
    sb.push_back(e);
  endtask

  // Monitor: trial-code log and scoreboard pop on done.
  always @(negedge clk) begin
    if (busy && (!prev_busy || dac_code != last_code)) trial.push_back(dac_code);
    prev_busy = busy;
    last_code = dac_code;
    if (done) begin
      exp_t e;
      done_cnt++;
      check("busy_fall_with_done", busy, 0);
      check("expect_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", result, e.val);
        check("latency", edge_cnt - e.se, LATENCY);
      end
    end
  end

  task automatic wait_done(input int maxc, output bit got);
    got = 0;
    for (int k = 0; k < maxc && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check("done_timeout", got, 1);
  endtask

  // One conversion; optional start pulses at cycles 10 and 30 while busy.
  task automatic run_conv(input logic [WIDTH-1:0] v, input bit pulses, output int busy_n);
    bit got;
    @(negedge clk);
    vin   = v;
    start = 1'b1;
    push_exp(v);
    busy_n = 0;
    got    = 0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      start = pulses && (k == 10 || k == 30);
      if (done) got = 1;
      else if (busy) busy_n++;
    end
    check("conv_timeout", got, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_trial [8];
    int  n;
    int  d0;
    bit  got;

    exp_trial = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    vin   = '0;
    repeat (3) @(negedge clk);
    check("rst_dac", dac_code, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal conversion with trial sequence and busy width.
    trial.delete();
    run_conv(8'hA5, 1'b0, n);
    check("busy_cycles", n, LATENCY);
    check("trial_count", trial.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < trial.size()) check("trial_code", trial[i], exp_trial[i]);

    // Endpoints.
    run_conv(8'h00, 1'b0, n);
    check("zero_dac", dac_code, 8'h00);
    run_conv(8'hFF, 1'b0, n);
    check("full_dac", dac_code, 8'hFF);

    // Starts during busy are ignored.
    run_conv(8'h3C, 1'b0, n);
    d0 = done_cnt;
    run_conv(8'h77, 1'b1, n);
    repeat (70) @(negedge clk);
    check("ignored_start_dones", done_cnt - d0, 1);
    check("ignored_start_busy", busy, 0);
    check("ignored_start_result", result, 8'h77);

    // Abort in IDLE clears the DAC and blocks a simultaneous start.
    run_conv(8'h40, 1'b0, n);
    check("pre_abort_dac", dac_code, 8'h40);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_dac", dac_code, 0);

    // Abort during a conversion.
    d0    = done_cnt;
    vin   = 8'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dac", dac_code, 0);
    check("abort_result", result, 8'h40);
    repeat (70) @(negedge clk);
    check("abort_no_done", done_cnt, d0);

    // start held high: back-to-back conversions.
    vin   = 8'h12;
    start = 1'b1;
    push_exp(8'h12);
    wait_done(200, got);
    vin = 8'hEE;
    push_exp(8'hEE);
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_dac", dac_code, 8'h80);
    wait_done(200, got);
    start = 1'b0;
    @(negedge clk);
    check("b2b_idle", busy, 0);
    check("b2b_result", result, 8'hEE);

    // Asynchronous reset mid-conversion.
    d0    = done_cnt;
    vin   = 8'h33;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_dac", dac_code, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("arst_no_done", done_cnt, d0);
    run_conv(8'h5A, 1'b0, n);
    check("post_rst_result", result, 8'h5A);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sar_adc_ctrl
`default_nettype wire
